// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter_if
// Brief    : Bundle of the CPU, aux and data-memory signals of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
  parameter int NBits = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [NBits-1:0] cpu_addr;
  logic [NBits-1:0] cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic             cpu_rvalid;
  logic [NBits-1:0] cpu_rdata;
  logic             cpu_err;

  logic             aux_req;
  logic             aux_we;
  logic [NBits-1:0] aux_addr;
  logic [NBits-1:0] aux_wdata;
  logic             aux_gnt;
  logic             aux_rvalid;
  logic [NBits-1:0] aux_rdata;
  logic             aux_err;

  logic             mem_we;
  logic             mem_re;
  logic [NBits-1:0] mem_addr;
  logic [NBits-1:0] mem_wdata;
  logic [NBits-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata, aux_err,
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata, aux_err,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares the data-memory port between the CPU MEM stage and an aux
//            loader port, with address translation and legality checking.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int               NBits        = 32,
  parameter int               MEMORY_DEPTH = 512,
  parameter logic [NBits-1:0] ADDR_OFFSET  = 'hFBFF_C000,
  parameter int               AUX_MAX_WAIT = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int               c_CNT_W    = $clog2(AUX_MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_WAIT = c_CNT_W'(AUX_MAX_WAIT);
  localparam logic [NBits-1:0] c_LIMIT    = NBits'(MEMORY_DEPTH * 4);

  logic [c_CNT_W-1:0] r_auxWaitCnt;
  logic               r_cpuRvalid;
  logic [NBits-1:0]   r_cpuRdata;
  logic               r_cpuErr;
  logic               r_auxRvalid;
  logic [NBits-1:0]   r_auxRdata;
  logic               r_auxErr;

  logic [NBits-1:0]   w_cpuTaddr;
  logic [NBits-1:0]   w_auxTaddr;
  logic               w_cpuLegal;
  logic               w_auxLegal;
  logic               w_auxForce;
  logic               w_cpuGnt;
  logic               w_auxGnt;
  logic               w_cpuResp;
  logic               w_auxResp;
  logic [NBits-1:0]   w_selTaddr;
  logic [NBits-1:0]   w_selWdata;
  logic               w_selWe;
  logic               w_selLegal;

  function automatic logic isLegal(input logic [NBits-1:0] taddr);
    return (taddr < c_LIMIT) && (taddr[1:0] == 2'b00);
  endfunction

  assign w_cpuTaddr = bus.cpu_addr + ADDR_OFFSET;
  assign w_auxTaddr = bus.aux_addr + ADDR_OFFSET;
  assign w_cpuLegal = isLegal(w_cpuTaddr);
  assign w_auxLegal = isLegal(w_auxTaddr);

  // CPU has priority until the aux port has starved for AUX_MAX_WAIT cycles.
  assign w_auxForce = (r_auxWaitCnt == c_MAX_WAIT);
  assign w_cpuGnt   = reset & bus.cpu_req & ~(bus.aux_req & w_auxForce);
  assign w_auxGnt   = reset & bus.aux_req & (~bus.cpu_req | w_auxForce);

  // Reads and illegal accesses produce a response; legal writes do not.
  assign w_cpuResp  = ~bus.cpu_we | ~w_cpuLegal;
  assign w_auxResp  = ~bus.aux_we | ~w_auxLegal;

  always_comb begin
    w_selTaddr = '0;
    w_selWdata = '0;
    w_selWe    = 1'b0;
    w_selLegal = 1'b0;
    if (w_auxGnt) begin
      w_selTaddr = w_auxTaddr;
      w_selWdata = bus.aux_wdata;
      w_selWe    = bus.aux_we;
      w_selLegal = w_auxLegal;
    end else if (w_cpuGnt) begin
      w_selTaddr = w_cpuTaddr;
      w_selWdata = bus.cpu_wdata;
      w_selWe    = bus.cpu_we;
      w_selLegal = w_cpuLegal;
    end
  end

  assign bus.mem_addr  = w_selTaddr;
  assign bus.mem_wdata = w_selWdata;
  assign bus.mem_we    = w_selLegal & w_selWe;
  assign bus.mem_re    = w_selLegal & ~w_selWe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_auxWaitCnt <= '0;
      r_cpuRvalid  <= 1'b0;
      r_cpuRdata   <= '0;
      r_cpuErr     <= 1'b0;
      r_auxRvalid  <= 1'b0;
      r_auxRdata   <= '0;
      r_auxErr     <= 1'b0;
    end else begin
      r_cpuRvalid <= w_cpuGnt & w_cpuResp;
      if (w_cpuGnt && w_cpuResp) begin
        r_cpuRdata <= w_cpuLegal ? bus.mem_rdata : '0;
        r_cpuErr   <= ~w_cpuLegal;
      end
      r_auxRvalid <= w_auxGnt & w_auxResp;
      if (w_auxGnt && w_auxResp) begin
        r_auxRdata <= w_auxLegal ? bus.mem_rdata : '0;
        r_auxErr   <= ~w_auxLegal;
      end
      if (bus.aux_req && !w_auxGnt) begin
        if (r_auxWaitCnt != c_MAX_WAIT) begin
          r_auxWaitCnt <= r_auxWaitCnt + 1'b1;
        end
      end else begin
        r_auxWaitCnt <= '0;
      end
    end
  end

  assign bus.cpu_gnt    = w_cpuGnt;
  assign bus.cpu_stall  = bus.cpu_req & ~w_cpuGnt;
  // A response launched just before reset is suppressed rather than shown.
  assign bus.cpu_rvalid = r_cpuRvalid & reset;
  assign bus.cpu_rdata  = r_cpuRdata;
  assign bus.cpu_err    = r_cpuErr;
  assign bus.aux_gnt    = w_auxGnt;
  assign bus.aux_rvalid = r_auxRvalid & reset;
  assign bus.aux_rdata  = r_auxRdata;
  assign bus.aux_err    = r_auxErr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed-vector bench with a response scoreboard for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam logic [31:0] c_OFFSET = 32'hFBFF_C000;
  localparam int          c_DEPTH  = 512;
  // Request address that translates to byte address 0.
  localparam logic [31:0] c_BASE   = 32'h0400_4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.NBits(32)) bus();

  dmem_port_arbiter #(
    .NBits(32), .MEMORY_DEPTH(c_DEPTH), .ADDR_OFFSET(c_OFFSET), .AUX_MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Data memory with combinational read, written on the clock edge.
  logic [31:0] mem    [0:c_DEPTH-1];
  logic [31:0] shadow [0:c_DEPTH-1];
  assign bus.mem_rdata = mem[bus.mem_addr[10:2]];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t cpuQ[$];
  resp_t auxQ[$];
  resp_t cpuExp, auxExp;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      if (cpuQ.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        cpuExp = cpuQ.pop_front();
        chk("cpu_rdata", bus.cpu_rdata, cpuExp.rdata);
        chk("cpu_err", {31'b0, bus.cpu_err}, {31'b0, cpuExp.err});
      end
    end
    if (bus.aux_rvalid === 1'b1) begin
      if (auxQ.size() == 0) begin
        total++; bad++;
        $display("FAIL aux_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        auxExp = auxQ.pop_front();
        chk("aux_rdata", bus.aux_rdata, auxExp.rdata);
        chk("aux_err", {31'b0, bus.aux_err}, {31'b0, auxExp.err});
      end
    end
  end

  task automatic setCpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic setAux(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.aux_req = req; bus.aux_we = we; bus.aux_addr = addr; bus.aux_wdata = wd;
  endtask

  // Checks one cycle's grant and strobes, and queues the expected response.
  task automatic access(input logic expCpu, input logic expAux, input bit dropResp, input string tag);
    logic [31:0] addr, wdata, taddr;
    logic        we, legal;
    resp_t       e;
    @(negedge clk);
    chk({tag, "_cpu_gnt"}, {31'b0, bus.cpu_gnt}, {31'b0, expCpu});
    chk({tag, "_aux_gnt"}, {31'b0, bus.aux_gnt}, {31'b0, expAux});
    chk({tag, "_cpu_stall"}, {31'b0, bus.cpu_stall}, {31'b0, bus.cpu_req & ~expCpu});
    addr  = expAux ? bus.aux_addr  : bus.cpu_addr;
    wdata = expAux ? bus.aux_wdata : bus.cpu_wdata;
    we    = expAux ? bus.aux_we    : bus.cpu_we;
    if (!(expCpu || expAux)) begin
      chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
      chk({tag, "_mem_re"}, {31'b0, bus.mem_re}, 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    end else begin
      taddr = addr + c_OFFSET;
      legal = (taddr < 32'(c_DEPTH * 4)) && (taddr[1:0] == 2'b00);
      chk({tag, "_mem_addr"}, bus.mem_addr, taddr);
      chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, {31'b0, legal & we});
      chk({tag, "_mem_re"}, {31'b0, bus.mem_re}, {31'b0, legal & ~we});
      if (legal && we) begin
        chk({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
        shadow[taddr[10:2]] = wdata;
      end
      if ((!we || !legal) && !dropResp) begin
        e.rdata = legal ? shadow[taddr[10:2]] : 32'd0;
        e.err   = ~legal;
        if (expAux) auxQ.push_back(e);
        else        cpuQ.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < c_DEPTH; i++) begin
      mem[i]    = 32'h0BAD_0000 | 32'(i);
      shadow[i] = 32'h0BAD_0000 | 32'(i);
    end
    reset = 1'b0;
    setCpu(1'b1, 1'b0, c_BASE, 32'd0);
    setAux(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset dominates a pending request.
    access(1'b0, 1'b0, 1'b0, "rst0");
    access(1'b0, 1'b0, 1'b0, "rst1");
    @(negedge clk);
    chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_cpu_err", {31'b0, bus.cpu_err}, 32'd0);
    chk("rst_aux_rvalid", {31'b0, bus.aux_rvalid}, 32'd0);
    chk("rst_aux_rdata", bus.aux_rdata, 32'd0);
    chk("rst_aux_err", {31'b0, bus.aux_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // CPU write then read of byte address 4.
    setCpu(1'b1, 1'b1, c_BASE + 32'd4, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 1'b0, "cpu_wr");
    setCpu(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
    access(1'b1, 1'b0, 1'b0, "cpu_rd");
    setCpu(1'b1, 1'b0, c_BASE + 32'h7FC, 32'd0);
    access(1'b1, 1'b0, 1'b0, "cpu_rd_top");

    // Illegal requests, issued back to back.
    setCpu(1'b1, 1'b0, c_BASE + 32'd2, 32'd0);
    access(1'b1, 1'b0, 1'b0, "misalign");
    setCpu(1'b1, 1'b1, c_BASE + 32'(4 * c_DEPTH), 32'h1111_1111);
    access(1'b1, 1'b0, 1'b0, "range_wr");
    setCpu(1'b1, 1'b0, 32'h1001_0004, 32'd0);
    access(1'b1, 1'b0, 1'b0, "wrap");
    setCpu(1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0);
    access(1'b1, 1'b0, 1'b0, "high");
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    access(1'b0, 1'b0, 1'b0, "idle0");

    // Aux-only traffic at byte address 0.
    setAux(1'b1, 1'b1, c_BASE, 32'hA5A5_0F0F);
    access(1'b0, 1'b1, 1'b0, "aux_wr");
    setAux(1'b1, 1'b0, c_BASE, 32'd0);
    access(1'b0, 1'b1, 1'b0, "aux_rd");
    setAux(1'b0, 1'b0, 32'd0, 32'd0);
    access(1'b0, 1'b0, 1'b0, "idle1");

    // Continuous contention: four CPU grants then one forced aux grant.
    setCpu(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
    setAux(1'b1, 1'b0, c_BASE, 32'd0);
    for (int i = 0; i < 10; i++) begin
      access(i % 5 != 4, i % 5 == 4, 1'b0, "arb");
    end
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    setAux(1'b0, 1'b0, 32'd0, 32'd0);
    access(1'b0, 1'b0, 1'b0, "idle2");

    // Reset right after a CPU read grant, with the aux wait count part-way up.
    setCpu(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
    setAux(1'b1, 1'b0, c_BASE, 32'd0);
    access(1'b1, 1'b0, 1'b0, "pre_rst");
    access(1'b1, 1'b0, 1'b1, "drop");
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
    chk("midrst_cpu_gnt", {31'b0, bus.cpu_gnt}, 32'd0);
    chk("midrst_mem_re", {31'b0, bus.mem_re}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      access(i < 4, i == 4, 1'b0, "post_rst");
    end
    setCpu(1'b0, 1'b0, 32'd0, 32'd0);
    setAux(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) access(1'b0, 1'b0, 1'b0, "drain");

    chk("cpu_queue_empty", 32'(cpuQ.size()), 32'd0);
    chk("aux_queue_empty", 32'(auxQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
